// File: rtl/program_sequencer.sv
// Clocked instruction sequencer: loadable code memory, register-based local memory,
// two-cycle fetch/execute per instruction and a valid/ready out channel.
module program_sequencer #(
    parameter int  MemoryElementWidth = 12,
    parameter int  NLocal             = 16,
    parameter int  NCode              = 32,
    parameter int  MaxSteps           = 1000,
    localparam int W                  = MemoryElementWidth,
    localparam int LA                 = $clog2(NLocal),
    localparam int CA                 = $clog2(NCode),
    localparam int IW                 = 6 + LA + 2 * W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CA-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          run,
    output logic          busy,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          finished,
    output logic          success,
    output logic          error,
    output logic [31:0]   steps
);

    localparam logic [3:0] OP_HALT = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_OUT  = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_JNZ  = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT_WAIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [IW-1:0] code      [NCode];
    logic [W-1:0]  local_mem [NLocal];
    logic [IW-1:0] instr;

    // One extra bit so that stepping past the last code word is detectable.
    logic [CA:0]   ip, ip_next, ip_inc;

    logic [3:0]    op;
    logic          a_imm, b_imm;
    logic [LA-1:0] tgt;
    logic [W-1:0]  a_fld, b_fld, opnd_a, opnd_b;
    logic [31:0]   steps_inc;
    logic          limit_hit;

    logic          idle, accept_run, fetch_ok, enter_done, set_error, set_success;
    logic          mem_we, out_load, out_ack;
    logic [W-1:0]  mem_wdata;

    assign {op, a_imm, b_imm, tgt, a_fld, b_fld} = instr;

    assign opnd_a    = a_imm ? a_fld : local_mem[a_fld[LA-1:0]];
    assign opnd_b    = b_imm ? b_fld : local_mem[b_fld[LA-1:0]];
    assign idle      = (state == S_IDLE) || (state == S_DONE);
    assign ip_inc    = ip + (CA + 1)'(1);
    assign steps_inc = steps + 32'd1;
    assign limit_hit = (steps_inc == 32'(MaxSteps)) && (op != OP_HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        ip_next     = ip;
        accept_run  = 1'b0;
        fetch_ok    = 1'b0;
        enter_done  = 1'b0;
        set_error   = 1'b0;
        set_success = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        out_load    = 1'b0;
        out_ack     = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (run) begin
                    accept_run = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ip >= (CA + 1)'(NCode)) begin
                    set_error  = 1'b1;
                    enter_done = 1'b1;
                    state_next = S_DONE;
                end else begin
                    fetch_ok   = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_FETCH;
                // The step limit aborts before the instruction has any effect.
                if (limit_hit) begin
                    set_error  = 1'b1;
                    enter_done = 1'b1;
                    state_next = S_DONE;
                end else begin
                    case (op)
                        OP_HALT: begin
                            set_success = 1'b1;
                            enter_done  = 1'b1;
                            state_next  = S_DONE;
                        end
                        OP_MOV: begin
                            mem_we    = 1'b1;
                            mem_wdata = opnd_a;
                            ip_next   = ip_inc;
                        end
                        OP_ADD: begin
                            mem_we    = 1'b1;
                            mem_wdata = opnd_a + opnd_b;
                            ip_next   = ip_inc;
                        end
                        OP_SUB: begin
                            mem_we    = 1'b1;
                            mem_wdata = opnd_a - opnd_b;
                            ip_next   = ip_inc;
                        end
                        OP_OUT: begin
                            out_load   = 1'b1;
                            state_next = S_OUT_WAIT;
                        end
                        OP_JZ:  ip_next = (opnd_a == '0) ? {1'b0, opnd_b[CA-1:0]} : ip_inc;
                        OP_JNZ: ip_next = (opnd_a != '0) ? {1'b0, opnd_b[CA-1:0]} : ip_inc;
                        default: begin
                            set_error  = 1'b1;
                            enter_done = 1'b1;
                            state_next = S_DONE;
                        end
                    endcase
                end
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    out_ack    = 1'b1;
                    ip_next    = ip_inc;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: code memory has no reset; a program survives reset and only the
    // local memory (a small register file) is cleared.
    always_ff @(posedge clock) begin
        if (load && idle) code[load_addr] <= load_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so later
    // statements in this block see the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip        <= '0;
            instr     <= '0;
            steps     <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            success   <= 1'b0;
            error     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NLocal; i++) local_mem[i] <= '0;
        end else begin
            ip <= ip_next;
            if (fetch_ok)         instr <= code[ip[CA-1:0]];
            if (state == S_EXEC)  steps <= steps_inc;
            if (mem_we)           local_mem[tgt] <= mem_wdata;
            if (set_error)        error <= 1'b1;
            if (set_success)      success <= !error;
            if (enter_done) begin
                finished <= 1'b1;
                busy     <= 1'b0;
            end
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= opnd_a;
            end
            if (out_ack)          out_valid <= 1'b0;
            if (accept_run) begin
                ip       <= '0;
                steps    <= '0;
                busy     <= 1'b1;
                finished <= 1'b0;
                success  <= 1'b0;
                error    <= 1'b0;
                for (int i = 0; i < NLocal; i++) local_mem[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: an instruction-level interpreter predicts out beats
// and final status; a per-cycle monitor compares the out channel against it.
module tb_program_sequencer;

    localparam int W        = 12;
    localparam int LA       = 4;
    localparam int CA       = 5;
    localparam int IW       = 6 + LA + 2 * W;
    localparam int NLocal   = 16;
    localparam int NCode    = 32;
    localparam int MaxSteps = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [CA-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          run = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, out_valid, finished, success, error;
    logic [W-1:0]  out_data;
    logic [31:0]   steps;

    program_sequencer #(
        .MemoryElementWidth(W),
        .NLocal            (NLocal),
        .NCode             (NCode),
        .MaxSteps          (MaxSteps)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_addr(load_addr),
        .load_data(load_data),
        .run      (run),
        .busy     (busy),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .finished (finished),
        .success  (success),
        .error    (error),
        .steps    (steps)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Bench-side copy of everything loaded, and the interpreter's predictions.
    logic [IW-1:0] model_code [NCode];
    logic [W-1:0]  exp_q [$];
    int            m_steps, m_nbeats;
    bit            m_success, m_error;
    logic [W-1:0]  m_first;
    bit            monitor_on = 1'b0;

    function automatic logic [IW-1:0] ins(input int op, input bit ai, input bit bi,
                                          input int tgt, input int a, input int b);
        return {4'(op), ai, bi, LA'(tgt), W'(a), W'(b)};
    endfunction

    task automatic run_model();
        logic [W-1:0]  mem [NLocal];
        logic [IW-1:0] w;
        logic [3:0]    op;
        logic          ai, bi;
        logic [LA-1:0] tgt;
        logic [W-1:0]  av, bv, a, b;
        int            ip;
        bit            stop;
        foreach (mem[i]) mem[i] = '0;
        exp_q.delete();
        ip = 0; m_steps = 0; m_success = 0; m_error = 0; stop = 0;
        while (!stop) begin
            if (ip >= NCode) begin
                m_error = 1; stop = 1;
            end else begin
                w = model_code[ip];
                {op, ai, bi, tgt, av, bv} = w;
                a = ai ? av : mem[av[LA-1:0]];
                b = bi ? bv : mem[bv[LA-1:0]];
                m_steps++;
                if (m_steps == MaxSteps && op != 0) begin
                    m_error = 1; stop = 1;
                end else begin
                    case (op)
                        0: begin m_success = 1; stop = 1; end
                        1: begin mem[tgt] = a;     ip++; end
                        2: begin mem[tgt] = a + b; ip++; end
                        3: begin mem[tgt] = a - b; ip++; end
                        4: begin exp_q.push_back(a); ip++; end
                        5: ip = (a == 0) ? int'(b) % NCode : ip + 1;
                        6: ip = (a != 0) ? int'(b) % NCode : ip + 1;
                        default: begin m_error = 1; stop = 1; end
                    endcase
                end
            end
        end
        m_nbeats = exp_q.size();
        m_first  = (m_nbeats > 0) ? exp_q[0] : '0;
    endtask

    // Out-channel monitor: every valid cycle must show the head of the expected stream.
    always @(negedge clock) begin
        if (monitor_on && !reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(out_data), 32'hDEAD);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (finished) check("busy_when_finished", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ld(input int addr, input logic [IW-1:0] w);
        load = 1'b1; load_addr = CA'(addr); load_data = w;
        model_code[addr] = w;
        tick();
        load = 1'b0;
    endtask

    // Optionally loads one word in the same cycle as the run pulse.
    task automatic launch(input bit with_load, input int addr, input logic [IW-1:0] w);
        if (with_load) model_code[addr] = w;
        run_model();
        load = with_load; load_addr = CA'(addr); load_data = w;
        run = 1'b1;
        tick();
        run = 1'b0; load = 1'b0;
    endtask

    task automatic pin_model(input string name, input int lsteps, input bit lsucc,
                             input bit lerr, input int lbeats, input logic [W-1:0] lfirst);
        check({name, "_model_steps"}, 32'(m_steps), 32'(lsteps));
        check({name, "_model_success"}, 32'(m_success), 32'(lsucc));
        check({name, "_model_error"}, 32'(m_error), 32'(lerr));
        check({name, "_model_beats"}, 32'(m_nbeats), 32'(lbeats));
        if (lbeats > 0) check({name, "_model_first"}, 32'(m_first), 32'(lfirst));
    endtask

    task automatic wait_done(input string name, input bit bp);
        int hold = 0;
        bit done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (finished) begin
                done = 1;
            end else begin
                if (out_valid) begin
                    out_ready = !bp || hold >= 5;
                    hold++;
                end else begin
                    out_ready = !bp;
                    hold = 0;
                end
                tick();
            end
        end
        out_ready = 1'b0;
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
        check({name, "_steps"}, steps, 32'(m_steps));
        check({name, "_success"}, 32'(success), 32'(m_success));
        check({name, "_error"}, 32'(error), 32'(m_error));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic load_countdown();
        ld(0, ins(1, 1, 0, 0, 3, 0));
        ld(1, ins(4, 0, 0, 0, 0, 0));
        ld(2, ins(3, 0, 1, 0, 0, 1));
        ld(3, ins(6, 0, 1, 0, 0, 1));
        ld(4, ins(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        bit seen;
        foreach (model_code[i]) model_code[i] = '0;

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_steps", steps, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        monitor_on = 1'b1;

        // sub/out/halt
        ld(0, ins(3, 1, 1, 0, 4, 2));
        ld(1, ins(4, 0, 0, 0, 0, 0));
        ld(2, ins(0, 0, 0, 0, 0, 0));
        launch(0, 0, '0);
        pin_model("basic", 3, 1, 0, 1, 12'd2);
        wait_done("basic", 0);
        check("basic_finished", 32'(finished), 32'd1);

        // countdown, consumer always ready
        load_countdown();
        launch(0, 0, '0);
        pin_model("count", 11, 1, 0, 3, 12'd3);
        wait_done("count", 0);

        // countdown with 5 cycles of backpressure per beat
        launch(0, 0, '0);
        pin_model("bp", 11, 1, 0, 3, 12'd3);
        wait_done("bp", 1);

        // wrap-around subtract; first word loaded in the run cycle
        ld(1, ins(4, 0, 0, 0, 0, 0));
        ld(2, ins(0, 0, 0, 0, 0, 0));
        launch(1, 0, ins(3, 1, 1, 0, 0, 1));
        pin_model("wrap", 3, 1, 0, 1, 12'hFFF);
        wait_done("wrap", 0);

        // illegal opcode at ip=1; the out of loc0 shows local memory was cleared by run
        ld(0, ins(4, 0, 0, 0, 0, 0));
        ld(1, ins(9, 0, 0, 0, 0, 0));
        launch(0, 0, '0);
        pin_model("illegal", 2, 0, 1, 1, 12'd0);
        wait_done("illegal", 0);
        check("illegal_finished", 32'(finished), 32'd1);

        // jz-to-self runs into the step limit
        ld(0, ins(5, 1, 1, 0, 0, 0));
        launch(0, 0, '0);
        pin_model("limit", 20, 0, 1, 0, '0);
        wait_done("limit", 0);

        // ip runs off the end of code memory
        ld(0, ins(5, 1, 1, 0, 0, 31));
        ld(31, ins(1, 1, 0, 1, 5, 0));
        launch(0, 0, '0);
        pin_model("overrun", 2, 0, 1, 0, '0);
        wait_done("overrun", 0);

        // reset while parked in OUT_WAIT, then re-run the retained program
        load_countdown();
        launch(0, 0, '0);
        out_ready = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            if (out_valid) seen = 1;
            else tick();
        end
        if (!seen) check("rst_mid_no_valid", 32'd1, 32'd0);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_data", 32'(out_data), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_steps", steps, 32'd0);
        check("rst_mid_finished", 32'(finished), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        launch(0, 0, '0);
        pin_model("rerun", 11, 1, 0, 3, 12'd3);
        wait_done("rerun", 0);

        monitor_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
